dual_spectrum_peak_finder: RTL and testbench

//  Downstream of the dual-channel FFT controller. Consumes the per-channel magnitude streams
//  (data/addr/valid) and, per completed frame, reports each channel's peak bin, peak magnitude
//  and both neighbour-bin magnitudes (for interpolation by the measurement/display logic).
//  The two channels are independent, identical per-channel engines.

---
 rtl/dual_spectrum_peak_finder.sv | 218 +++++++++++++++++++++
 tb/tb_dual_spectrum_peak_finder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_spectrum_peak_finder.sv
// Two independent per-channel peak search engines over FFT magnitude frames.
// Optional feature macro: PEAK_THRESHOLD_EN (adds peak_threshold input, gates publishing).

module dspf_engine #(
   parameter int FRAME_LEN = 8192,
   parameter int ADDR_W    = 13,
   parameter int MAG_W     = 16,
   parameter int MIN_BIN   = 1,
   parameter int MAX_BIN   = 4095
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [MAG_W-1:0]  i_data,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_valid,
`ifdef PEAK_THRESHOLD_EN
   input  logic [MAG_W-1:0]  i_thr,
`endif
   output logic [MAG_W-1:0]  o_peak_mag,
   output logic [ADDR_W-1:0] o_peak_bin,
   output logic [MAG_W-1:0]  o_left_mag,
   output logic [MAG_W-1:0]  o_right_mag,
   output logic              o_peak_valid,
   output logic              o_frame_err,
   output logic [7:0]        o_err_cnt,
   output logic [1:0]        o_state
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_DONE = 2'd2} state_t;

   state_t            r_state, w_state_nxt;
   logic              w_take, w_clear, w_last, w_err, w_pass, w_upd;
   logic [MAG_W-1:0]  r_max, r_left, r_right, r_prev;
   logic [ADDR_W-1:0] r_bin, r_exp;
   logic              r_pend;
   logic [MAG_W-1:0]  w_max_n, w_left_n, w_right_n, w_prev_n;
   logic [ADDR_W-1:0] w_bin_n, w_exp_n;
   logic              w_pend_n;

   assign o_state = r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_clear     = 1'b0;
      w_last      = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_valid && i_addr == '0) begin
               w_clear     = 1'b1;
               w_take      = 1'b1;
               w_state_nxt = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (i_valid) begin
               if (i_addr == r_exp) begin
                  w_take = 1'b1;
                  if (i_addr == LAST) begin
                     w_last      = 1'b1;
                     w_state_nxt = S_DONE;
                  end
               end else if (i_addr == '0) begin
                  // Out-of-order frame start: restart in place, but still an error.
                  w_clear = 1'b1;
                  w_take  = 1'b1;
                  w_err   = 1'b1;
               end else begin
                  w_err       = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Working values after this cycle's sample; the final sample is folded in
   // before publishing so a peak or right neighbour on the last bin is not lost.
   always_comb begin
      w_max_n   = w_clear ? '0 : r_max;
      w_bin_n   = w_clear ? ADDR_W'(MIN_BIN) : r_bin;
      w_left_n  = w_clear ? '0 : r_left;
      w_right_n = w_clear ? '0 : r_right;
      w_pend_n  = w_clear ? 1'b0 : r_pend;
      w_prev_n  = w_clear ? '0 : r_prev;
      w_exp_n   = r_exp;
      w_upd     = 1'b0;
      if (w_take) begin
         w_upd = (i_addr >= ADDR_W'(MIN_BIN)) && (i_addr <= ADDR_W'(MAX_BIN)) &&
                 (i_data > w_max_n);
         if (w_upd) begin
            w_max_n   = i_data;
            w_bin_n   = i_addr;
            w_left_n  = w_prev_n;
            w_right_n = '0;
            w_pend_n  = 1'b1;
         end else if (w_pend_n) begin
            w_right_n = i_data;
            w_pend_n  = 1'b0;
         end
         w_prev_n = i_data;
         w_exp_n  = i_addr + ADDR_W'(1);
      end
   end

`ifdef PEAK_THRESHOLD_EN
   assign w_pass = (w_max_n >= i_thr);
`else
   assign w_pass = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_max        <= '0;
         r_bin        <= '0;
         r_left       <= '0;
         r_right      <= '0;
         r_pend       <= 1'b0;
         r_prev       <= '0;
         r_exp        <= '0;
         o_peak_mag   <= '0;
         o_peak_bin   <= '0;
         o_left_mag   <= '0;
         o_right_mag  <= '0;
         o_peak_valid <= 1'b0;
         o_frame_err  <= 1'b0;
         o_err_cnt    <= '0;
      end else begin
         r_max        <= w_max_n;
         r_bin        <= w_bin_n;
         r_left       <= w_left_n;
         r_right      <= w_right_n;
         r_pend       <= w_pend_n;
         r_prev       <= w_prev_n;
         r_exp        <= w_exp_n;
         o_peak_valid <= w_last && w_pass;
         o_frame_err  <= w_err;
         if (w_last && w_pass) begin
            o_peak_mag  <= w_max_n;
            o_peak_bin  <= w_bin_n;
            o_left_mag  <= w_left_n;
            o_right_mag <= w_right_n;
         end
         if (w_err && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
      end
   end
endmodule

module dual_spectrum_peak_finder #(
   parameter int FRAME_LEN = 8192,
   parameter int ADDR_W    = 13,
   parameter int MAG_W     = 16,
   parameter int MIN_BIN   = 1,
   parameter int MAX_BIN   = 4095
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [MAG_W-1:0]  ch1_spec_data,
   input  logic [ADDR_W-1:0] ch1_spec_addr,
   input  logic              ch1_spec_valid,
   input  logic [MAG_W-1:0]  ch2_spec_data,
   input  logic [ADDR_W-1:0] ch2_spec_addr,
   input  logic              ch2_spec_valid,
`ifdef PEAK_THRESHOLD_EN
   input  logic [MAG_W-1:0]  peak_threshold,
`endif
   output logic [MAG_W-1:0]  ch1_peak_mag,
   output logic [ADDR_W-1:0] ch1_peak_bin,
   output logic [MAG_W-1:0]  ch1_left_mag,
   output logic [MAG_W-1:0]  ch1_right_mag,
   output logic              ch1_peak_valid,
   output logic              ch1_frame_err,
   output logic [7:0]        ch1_err_cnt,
   output logic [MAG_W-1:0]  ch2_peak_mag,
   output logic [ADDR_W-1:0] ch2_peak_bin,
   output logic [MAG_W-1:0]  ch2_left_mag,
   output logic [MAG_W-1:0]  ch2_right_mag,
   output logic              ch2_peak_valid,
   output logic              ch2_frame_err,
   output logic [7:0]        ch2_err_cnt,
   output logic [1:0]        o_ch1_state,
   output logic [1:0]        o_ch2_state
);
   dspf_engine #(.FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W), .MAG_W(MAG_W),
                 .MIN_BIN(MIN_BIN), .MAX_BIN(MAX_BIN)) u_ch1 (
      .clk(clk), .rst_n(rst_n),
      .i_data(ch1_spec_data), .i_addr(ch1_spec_addr), .i_valid(ch1_spec_valid),
`ifdef PEAK_THRESHOLD_EN
      .i_thr(peak_threshold),
`endif
      .o_peak_mag(ch1_peak_mag), .o_peak_bin(ch1_peak_bin),
      .o_left_mag(ch1_left_mag), .o_right_mag(ch1_right_mag),
      .o_peak_valid(ch1_peak_valid), .o_frame_err(ch1_frame_err),
      .o_err_cnt(ch1_err_cnt), .o_state(o_ch1_state)
   );

   dspf_engine #(.FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W), .MAG_W(MAG_W),
                 .MIN_BIN(MIN_BIN), .MAX_BIN(MAX_BIN)) u_ch2 (
      .clk(clk), .rst_n(rst_n),
      .i_data(ch2_spec_data), .i_addr(ch2_spec_addr), .i_valid(ch2_spec_valid),
`ifdef PEAK_THRESHOLD_EN
      .i_thr(peak_threshold),
`endif
      .o_peak_mag(ch2_peak_mag), .o_peak_bin(ch2_peak_bin),
      .o_left_mag(ch2_left_mag), .o_right_mag(ch2_right_mag),
      .o_peak_valid(ch2_peak_valid), .o_frame_err(ch2_frame_err),
      .o_err_cnt(ch2_err_cnt), .o_state(o_ch2_state)
   );
endmodule

// File: tb/tb_dual_spectrum_peak_finder.sv
// Scoreboard bench for dual_spectrum_peak_finder: frame-array reference model,
// expected-result queues per channel, negedge monitors that pop and compare.
`timescale 1ns/1ps

module tb_dual_spectrum_peak_finder;
   localparam int FL = 8192, MINB = 1, MAXB = 4095, EW = 102;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] ch1_spec_data = '0, ch2_spec_data = '0;
   logic [12:0] ch1_spec_addr = '0, ch2_spec_addr = '0;
   logic        ch1_spec_valid = 1'b0, ch2_spec_valid = 1'b0;
`ifdef PEAK_THRESHOLD_EN
   logic [15:0] peak_threshold = '0;
`endif
   logic [15:0] ch1_peak_mag, ch1_left_mag, ch1_right_mag;
   logic [15:0] ch2_peak_mag, ch2_left_mag, ch2_right_mag;
   logic [12:0] ch1_peak_bin, ch2_peak_bin;
   logic        ch1_peak_valid, ch1_frame_err, ch2_peak_valid, ch2_frame_err;
   logic [7:0]  ch1_err_cnt, ch2_err_cnt;
   logic [1:0]  o_ch1_state, o_ch2_state;

   dual_spectrum_peak_finder dut (
      .clk(clk), .rst_n(rst_n),
      .ch1_spec_data(ch1_spec_data), .ch1_spec_addr(ch1_spec_addr), .ch1_spec_valid(ch1_spec_valid),
      .ch2_spec_data(ch2_spec_data), .ch2_spec_addr(ch2_spec_addr), .ch2_spec_valid(ch2_spec_valid),
`ifdef PEAK_THRESHOLD_EN
      .peak_threshold(peak_threshold),
`endif
      .ch1_peak_mag(ch1_peak_mag), .ch1_peak_bin(ch1_peak_bin), .ch1_left_mag(ch1_left_mag),
      .ch1_right_mag(ch1_right_mag), .ch1_peak_valid(ch1_peak_valid), .ch1_frame_err(ch1_frame_err),
      .ch1_err_cnt(ch1_err_cnt),
      .ch2_peak_mag(ch2_peak_mag), .ch2_peak_bin(ch2_peak_bin), .ch2_left_mag(ch2_left_mag),
      .ch2_right_mag(ch2_right_mag), .ch2_peak_valid(ch2_peak_valid), .ch2_frame_err(ch2_frame_err),
      .ch2_err_cnt(ch2_err_cnt),
      .o_ch1_state(o_ch1_state), .o_ch2_state(o_ch2_state)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // Scoreboard entry: {kind(1:err), bin13, mag16, left16, right16, err8, cycle32}
   logic [EW-1:0] exp_q1[$];
   logic [EW-1:0] exp_q2[$];

   // Reference model state
   logic [15:0] pat     [2][FL];
   logic [15:0] m_frame [2][FL];
   bit          m_in    [2];
   int          m_exp   [2];
   int          m_err   [2];
   int          m_done  [2];
   logic [60:0] m_pub   [2];

   task automatic chk(input string nm, input int ch, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s ch%0d: got %0d expected %0d (t=%0t)", nm, ch + 1, act, exp, $time);
      end
   endtask

   task automatic push(input int ch, input logic [EW-1:0] e);
      if (ch == 0) exp_q1.push_back(e);
      else         exp_q2.push_back(e);
   endtask

   task automatic model_reset();
      for (int ch = 0; ch < 2; ch++) begin
         m_in[ch] = 1'b0; m_exp[ch] = 0; m_err[ch] = 0; m_done[ch] = -10; m_pub[ch] = '0;
      end
   endtask

   // Frame complete: scan the stored frame for the lowest-index strict maximum.
   task automatic model_publish(input int ch, input int c);
      logic [15:0] mx, lf, rt;
      int          bn;
      bit          pass;
      mx = '0; bn = MINB;
      for (int b = MINB; b <= MAXB; b++)
         if (m_frame[ch][b] > mx) begin mx = m_frame[ch][b]; bn = b; end
      lf = (bn > 0) ? m_frame[ch][bn - 1] : 16'd0;
      rt = (bn == FL - 1) ? 16'd0 : m_frame[ch][bn + 1];
      pass = 1'b1;
`ifdef PEAK_THRESHOLD_EN
      pass = (mx >= peak_threshold);
`endif
      if (pass) begin
         m_pub[ch] = {13'(bn), mx, lf, rt};
         push(ch, {1'b0, 13'(bn), mx, lf, rt, 8'(m_err[ch]), 32'(c + 1)});
      end
   endtask

   task automatic model_sample(input int ch, input int addr, input logic [15:0] data, input int c);
      if (c == m_done[ch] + 1) return;
      if (!m_in[ch]) begin
         if (addr == 0) begin m_in[ch] = 1'b1; m_frame[ch][0] = data; m_exp[ch] = 1; end
      end else if (addr != m_exp[ch]) begin
         if (m_err[ch] < 255) m_err[ch]++;
         push(ch, {1'b1, 13'd0, 16'd0, 16'd0, 16'd0, 8'(m_err[ch]), 32'(c + 1)});
         if (addr == 0) begin m_frame[ch][0] = data; m_exp[ch] = 1; end
         else m_in[ch] = 1'b0;
      end else begin
         m_frame[ch][addr] = data;
         m_exp[ch] = (addr + 1) % FL;
         if (addr == FL - 1) begin
            m_in[ch] = 1'b0; m_done[ch] = c;
            model_publish(ch, c);
         end
      end
   endtask

   task automatic drive(input bit v1, input int a1, input logic [15:0] d1,
                        input bit v2, input int a2, input logic [15:0] d2);
      int c;
      @(posedge clk); #1;
      c = cyc;
      ch1_spec_valid = v1; ch1_spec_addr = 13'(a1); ch1_spec_data = d1;
      ch2_spec_valid = v2; ch2_spec_addr = 13'(a2); ch2_spec_data = d2;
      if (v1) model_sample(0, a1, d1, c);
      if (v2) model_sample(1, a2, d2, c);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 16'd0, 0, 0, 16'd0);
   endtask

   task automatic fill(input int ch, input int lo, input int hi);
      for (int a = 0; a < FL; a++) pat[ch][a] = 16'($urandom_range(hi, lo));
   endtask

   // Plays one frame; ch1 may skip the address after jump1, and play may stop after addr 'stop'.
   task automatic play(input bit en1, input bit en2, input int jump1, input int stop);
      for (int a = 0; a < FL; a++) begin
         int a1;
         bit v1;
         if ($urandom_range(31, 0) == 0) drive(0, 0, 16'd0, 0, 0, 16'd0);
         a1 = (jump1 >= 0 && a > jump1) ? a + 1 : a;
         v1 = en1 && (a1 < FL);
         drive(v1, a1, v1 ? pat[0][a1] : 16'd0, en2, a, pat[1][a]);
         if (stop >= 0 && a == stop) break;
      end
      idle(2);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (exp_q1.size() + exp_q2.size()) != 0; i++) @(negedge clk);
      chk("queue_drained", 0, 64'(exp_q1.size() + exp_q2.size()), 64'd0);
   endtask

   task automatic check_hold(input int ch);
      @(negedge clk);
      if (ch == 0) begin
         chk("hold_results", ch, {ch1_peak_bin, ch1_peak_mag, ch1_left_mag, ch1_right_mag}, m_pub[0]);
         chk("hold_err_cnt", ch, ch1_err_cnt, m_err[0]);
      end else begin
         chk("hold_results", ch, {ch2_peak_bin, ch2_peak_mag, ch2_left_mag, ch2_right_mag}, m_pub[1]);
         chk("hold_err_cnt", ch, ch2_err_cnt, m_err[1]);
      end
   endtask

   task automatic check_zero();
      @(negedge clk);
      chk("reset_ch1_outputs", 0, {ch1_peak_bin, ch1_peak_mag, ch1_left_mag, ch1_right_mag,
          ch1_peak_valid, ch1_frame_err, ch1_err_cnt}, 64'd0);
      chk("reset_ch2_outputs", 1, {ch2_peak_bin, ch2_peak_mag, ch2_left_mag, ch2_right_mag,
          ch2_peak_valid, ch2_frame_err, ch2_err_cnt}, 64'd0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      ch1_spec_valid = 1'b0; ch2_spec_valid = 1'b0;
      rst_n = 1'b0;
      model_reset();
      check_zero();
      check_zero();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic monitor(input int ch, input bit pv, input bit fe, input logic [12:0] bn,
                          input logic [15:0] mg, input logic [15:0] lf, input logic [15:0] rt,
                          input logic [7:0] ec);
      logic [EW-1:0] e;
      if ((ch == 0 ? exp_q1.size() : exp_q2.size()) == 0) begin
         chk("unexpected_pulse", ch, {pv, fe}, 64'd0);
         return;
      end
      e = (ch == 0) ? exp_q1.pop_front() : exp_q2.pop_front();
      chk("pulse_kind", ch, {pv, fe}, e[101] ? 64'd1 : 64'd2);
      chk("pulse_cycle", ch, 64'(cyc), 64'(e[31:0]));
      chk("err_cnt", ch, ec, e[39:32]);
      if (!e[101]) begin
         chk("peak_bin", ch, bn, e[100:88]);
         chk("peak_mag", ch, mg, e[87:72]);
         chk("left_mag", ch, lf, e[71:56]);
         chk("right_mag", ch, rt, e[55:40]);
      end
   endtask

   always @(negedge clk)
      if (rst_n && (ch1_peak_valid || ch1_frame_err))
         monitor(0, ch1_peak_valid, ch1_frame_err, ch1_peak_bin, ch1_peak_mag,
                 ch1_left_mag, ch1_right_mag, ch1_err_cnt);

   always @(negedge clk)
      if (rst_n && (ch2_peak_valid || ch2_frame_err))
         monitor(1, ch2_peak_valid, ch2_frame_err, ch2_peak_bin, ch2_peak_mag,
                 ch2_left_mag, ch2_right_mag, ch2_err_cnt);

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      check_zero();
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(3);

      // Single peak with distinct neighbours on ch1, ch2 idle
      for (int a = 0; a < FL; a++) pat[0][a] = 16'd10;
      pat[0][99] = 16'd300; pat[0][100] = 16'd500; pat[0][101] = 16'd200;
      play(1, 0, -1, -1);
      drain();
      @(negedge clk);
      chk("t1_const", 0, {ch1_peak_bin, ch1_peak_mag, ch1_left_mag, ch1_right_mag},
          {13'd100, 16'd500, 16'd300, 16'd200});
      check_hold(1);

      // Tie and large DC bin on ch1; small-range random (many ties) on ch2
      fill(0, 1, 100);
      pat[0][0] = 16'd9000; pat[0][50] = 16'd700; pat[0][60] = 16'd700;
      fill(1, 1, 40);
      play(1, 1, -1, -1);
      drain();
      @(negedge clk);
      chk("t2_const", 0, {ch1_peak_bin, ch1_peak_mag}, {13'd50, 16'd700});

      // Address jump 2000->2002 on ch1, then a clean frame
      fill(0, 1, 65535);
      fill(1, 1, 65535);
      play(1, 1, 2000, -1);
      drain();
      check_hold(0);
      fill(0, 1, 65535);
      play(1, 0, -1, -1);
      drain();
      check_hold(0);

      // Both channels together; ch2 peak on last eligible bin, bigger value outside window
      fill(0, 1, 65535);
      fill(1, 1, 500);
      pat[1][4095] = 16'd1000; pat[1][4096] = 16'd800; pat[1][5000] = 16'd65000;
      play(1, 1, -1, -1);
      drain();
      @(negedge clk);
      chk("t4_const", 1, {ch2_peak_bin, ch2_peak_mag, ch2_right_mag}, {13'd4095, 16'd1000, 16'd800});

      // Reset mid-frame, then a fresh frame
      fill(0, 1, 65535);
      play(1, 0, -1, 3000);
      do_reset();
      idle(2);
      play(1, 0, -1, -1);
      drain();
      check_hold(0);
      check_hold(1);

      // Error counter saturation on ch2: alternate restart and abort errors
      for (int i = 0; i < 150; i++) begin
         drive(0, 0, 16'd0, 1, 0, 16'($urandom));
         drive(0, 0, 16'd0, 1, 1, 16'($urandom));
         drive(0, 0, 16'd0, 1, 0, 16'($urandom));
         drive(0, 0, 16'd0, 1, int'($urandom_range(9, 3)), 16'($urandom));
      end
      idle(3);
      drain();
      check_hold(1);
      @(negedge clk);
      chk("err_saturated", 1, ch2_err_cnt, 64'd255);

`ifdef PEAK_THRESHOLD_EN
      peak_threshold = 16'd600;
      for (int a = 0; a < FL; a++) pat[0][a] = 16'd10;
      pat[0][99] = 16'd300; pat[0][100] = 16'd500; pat[0][101] = 16'd200;
      play(1, 0, -1, -1);
      drain();
      check_hold(0);
      pat[0][100] = 16'd700;
      play(1, 0, -1, -1);
      drain();
      @(negedge clk);
      chk("thr_publish", 0, {ch1_peak_bin, ch1_peak_mag}, {13'd100, 16'd700});
`endif

      idle(4);
      chk("final_queue_empty", 0, 64'(exp_q1.size() + exp_q2.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
